// File: rtl/race_pkg.sv
// Shared definitions for the race controller: state encoding, track zone bounds,
// car-centre offset, tick rate and small arithmetic helpers.
package race_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_RACE  = 2'd2,
    S_DONE  = 2'd3
  } race_state_e;

  localparam int TICK_HZ = 100;

  localparam logic [10:0] CAR_OFFSET = 11'd32;

  // Finish line and checkpoint share an x band; they differ only in y.
  localparam logic [10:0] FIN_X_LO = 11'd400;
  localparam logic [10:0] FIN_X_HI = 11'd415;
  localparam logic [10:0] FIN_Y_LO = 11'd16;
  localparam logic [10:0] FIN_Y_HI = 11'd160;
  localparam logic [10:0] CP_X_LO  = 11'd400;
  localparam logic [10:0] CP_X_HI  = 11'd415;
  localparam logic [10:0] CP_Y_LO  = 11'd608;
  localparam logic [10:0] CP_Y_HI  = 11'd752;

  function automatic logic in_box(input logic [10:0] x, input logic [10:0] y,
                                  input logic [10:0] x_lo, input logic [10:0] x_hi,
                                  input logic [10:0] y_lo, input logic [10:0] y_hi);
    return (x >= x_lo) && (x <= x_hi) && (y >= y_lo) && (y <= y_hi);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/race_ctl_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clock cycles.
module tick_gen #(
  parameter int DIV = 650000
) (
  input  logic pclk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/race_ctl.sv
// Race controller: countdown, lap counting via checkpoint/finish zones, race timer.
// Optional best-lap timing is enabled by defining RACE_BEST_LAP_EN.
module race_ctl
  import race_pkg::*;
#(
  parameter int CLK_HZ  = 65000000,
  parameter int LAPS    = 3,
  parameter int COUNT_S = 3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  output logic        car_en,
  output logic [1:0]  race_state,
  output logic [2:0]  countdown,
  output logic [2:0]  lap,
  output logic [15:0] race_time,
  output logic [15:0] best_lap
);

  localparam int          DIV      = CLK_HZ / TICK_HZ;
  localparam logic [2:0]  LAPS_L   = 3'(LAPS);
  localparam logic [2:0]  COUNT_L  = 3'(COUNT_S);
  localparam logic [6:0]  SUB_LAST = 7'(TICK_HZ - 1);

  logic tick;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .pclk (pclk),
    .rst  (rst),
    .tick (tick)
  );

  logic [10:0] cx, cy;
  logic        fin_now, cp_now;

  assign cx      = xpos + CAR_OFFSET;
  assign cy      = ypos + CAR_OFFSET;
  assign fin_now = in_box(cx, cy, FIN_X_LO, FIN_X_HI, FIN_Y_LO, FIN_Y_HI);
  assign cp_now  = in_box(cx, cy, CP_X_LO, CP_X_HI, CP_Y_LO, CP_Y_HI);

  race_state_e state_q, state_d;
  logic [2:0]  countdown_q, countdown_d;
  logic [2:0]  lap_q, lap_d;
  logic [15:0] race_time_q, race_time_d;
  logic [6:0]  sub_q, sub_d;
  logic        cp_seen_q, cp_seen_d;
  logic        car_en_q, car_en_d;
  logic        fin_q, fin_prev_q, cp_q, cp_prev_q;
  logic        fin_entry, cp_entry;

`ifdef RACE_BEST_LAP_EN
  logic [15:0] lap_time_q, lap_time_d, lap_time_inc;
  logic [15:0] best_lap_q, best_lap_d;
`endif

  // Entry is the rising edge of the registered zone flag.
  assign fin_entry = fin_q & ~fin_prev_q;
  assign cp_entry  = cp_q & ~cp_prev_q;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    lap_d       = lap_q;
    race_time_d = race_time_q;
    sub_d       = sub_q;
    cp_seen_d   = cp_seen_q;
    car_en_d    = (state_q == S_RACE);
`ifdef RACE_BEST_LAP_EN
    lap_time_inc = tick ? sat_inc16(lap_time_q) : lap_time_q;
    lap_time_d   = lap_time_q;
    best_lap_d   = best_lap_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_COUNT;
          countdown_d = COUNT_L;
          lap_d       = '0;
          race_time_d = '0;
          cp_seen_d   = 1'b0;
          sub_d       = '0;
`ifdef RACE_BEST_LAP_EN
          lap_time_d  = '0;
`endif
        end
      end

      S_COUNT: begin
        if (tick) begin
          if (sub_q == SUB_LAST) begin
            sub_d       = '0;
            countdown_d = countdown_q - 3'd1;
            if (countdown_q == 3'd1) state_d = S_RACE;
          end else begin
            sub_d = sub_q + 7'd1;
          end
        end
      end

      S_RACE: begin
        if (tick) race_time_d = sat_inc16(race_time_q);
`ifdef RACE_BEST_LAP_EN
        if (lap_q != LAPS_L) lap_time_d = lap_time_inc;
`endif
        if (lap_q == LAPS_L) begin
          state_d = S_DONE;
        end else begin
          // Finish is judged before the checkpoint of the same cycle is recorded.
          if (fin_entry && cp_seen_q) begin
            lap_d     = lap_q + 3'd1;
            cp_seen_d = 1'b0;
`ifdef RACE_BEST_LAP_EN
            if (lap_time_inc < best_lap_q) best_lap_d = lap_time_inc;
            lap_time_d = '0;
`endif
          end
          if (cp_entry) cp_seen_d = 1'b1;
        end
      end

      S_DONE: begin
        if (start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      countdown_q <= '0;
      lap_q       <= '0;
      race_time_q <= '0;
      sub_q       <= '0;
      cp_seen_q   <= 1'b0;
      car_en_q    <= 1'b0;
      fin_q       <= 1'b0;
      fin_prev_q  <= 1'b0;
      cp_q        <= 1'b0;
      cp_prev_q   <= 1'b0;
`ifdef RACE_BEST_LAP_EN
      lap_time_q  <= '0;
      best_lap_q  <= 16'hFFFF;
`endif
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      lap_q       <= lap_d;
      race_time_q <= race_time_d;
      sub_q       <= sub_d;
      cp_seen_q   <= cp_seen_d;
      car_en_q    <= car_en_d;
      fin_q       <= fin_now;
      fin_prev_q  <= fin_q;
      cp_q        <= cp_now;
      cp_prev_q   <= cp_q;
`ifdef RACE_BEST_LAP_EN
      lap_time_q  <= lap_time_d;
      best_lap_q  <= best_lap_d;
`endif
    end
  end

  assign car_en     = car_en_q;
  assign race_state = state_q;
  assign countdown  = countdown_q;
  assign lap        = lap_q;
  assign race_time  = race_time_q;
`ifdef RACE_BEST_LAP_EN
  assign best_lap   = best_lap_q;
`else
  assign best_lap   = '0;
`endif

endmodule

// File: tb/tb_race_ctl.sv
// Scoreboard bench for race_ctl: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them whenever the visible outputs change.
module tb_race_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] xpos = 11'd100;
  logic [10:0] ypos = 11'd300;
  logic        car_en;
  logic [1:0]  race_state;
  logic [2:0]  countdown;
  logic [2:0]  lap;
  logic [15:0] race_time;
  logic [15:0] best_lap;

  race_ctl #(.CLK_HZ(1000), .LAPS(3), .COUNT_S(3)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .start      (start),
    .xpos       (xpos),
    .ypos       (ypos),
    .car_en     (car_en),
    .race_state (race_state),
    .countdown  (countdown),
    .lap        (lap),
    .race_time  (race_time),
    .best_lap   (best_lap)
  );

  always #5 pclk = ~pclk;

`ifdef RACE_BEST_LAP_EN
  localparam logic [15:0] BEST_RST  = 16'hFFFF;
  localparam logic [15:0] BEST_LAP1 = 16'd50;
  localparam logic [15:0] BEST_FIN  = 16'd30;
`else
  localparam logic [15:0] BEST_RST  = 16'd0;
  localparam logic [15:0] BEST_LAP1 = 16'd0;
  localparam logic [15:0] BEST_FIN  = 16'd0;
`endif

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [8:0] snap;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input string nm, input int st, input int cd, input int lp, input int en);
    exp_t e;
    e.snap = {2'(st), 3'(cd), 3'(lp), 1'(en)};
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: any change of {state, countdown, lap, car_en} is an output event.
  logic [8:0]  prev_snap;
  logic [8:0]  cur_snap;
  bit          mon_en = 1'b0;
  bit          race_seen = 1'b0;
  int unsigned race_cyc = 0;
  exp_t        mon_e;

  assign cur_snap = {race_state, countdown, lap, car_en};

  always @(negedge pclk) begin
    if (mon_en && (cur_snap !== prev_snap)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected no change from %0h (cycle %0d)",
                 cur_snap, prev_snap, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check(mon_e.name, 32'(cur_snap), 32'(mon_e.snap));
      end
      if (race_state == 2'd2 && prev_snap[8:7] != 2'd2) begin
        race_seen = 1'b1;
        race_cyc  = cyc;
      end
    end
    prev_snap = cur_snap;
  end

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic at(input int unsigned t);
    while (cyc < t) @(negedge pclk);
  endtask

  task automatic set_pos(input int x, input int y);
    xpos = 11'(x);
    ypos = 11'(y);
  endtask

  task automatic pulse_start;
    @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_cd(input logic [2:0] val, output int unsigned t);
    int n;
    n = 0;
    while (countdown !== val && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    if (countdown !== val) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_countdown_%0d: got %0d expected %0d within 3000 cycles", val, countdown, val);
    end
    t = cyc;
  endtask

  task automatic wait_race(output int unsigned t);
    int n;
    n = 0;
    while (!race_seen && n < 4000) begin
      @(negedge pclk);
      n++;
    end
    if (!race_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_race: got state %0d expected 2 within 4000 cycles", race_state);
      race_cyc = cyc;
    end
    t = race_cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},     32'(race_state), 32'd0);
    check({tag, "_countdown"}, 32'(countdown),  32'd0);
    check({tag, "_lap"},       32'(lap),        32'd0);
    check({tag, "_car_en"},    32'(car_en),     32'd0);
    check({tag, "_race_time"}, 32'(race_time),  32'd0);
    check({tag, "_best_lap"},  32'(best_lap),   32'(BEST_RST));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t2, t1, e0, e1;

    step(3);
    rst = 1'b0;
    step(1);
    check_reset_outputs("rst");
    mon_en = 1'b1;

    // Race 1: countdown 3,2,1 then RACE, car_en one cycle after the state.
    push("count_enter", 1, 3, 0, 0);
    push("count_2",     1, 2, 0, 0);
    push("count_1",     1, 1, 0, 0);
    push("race_enter",  2, 0, 0, 0);
    push("car_en_on",   2, 0, 0, 1);
    race_seen = 1'b0;
    pulse_start;
    step(5);
    pulse_start;                      // ignored during COUNT
    wait_cd(3'd2, t2);
    wait_cd(3'd1, t1);
    check("cd_interval", t1 - t2, 32'd1000);
    wait_race(e0);
    check("race_delay", e0 - t1, 32'd1000);

    // Finish without checkpoint: no lap.
    at(e0 + 20);  set_pos(370, 50);
    at(e0 + 60);  set_pos(100, 300);
    at(e0 + 100); check("lap_no_cp", 32'(lap), 32'd0);
    at(e0 + 120); set_pos(370, 650);
    at(e0 + 200); set_pos(100, 300);
    at(e0 + 300); pulse_start;        // ignored during RACE

    // Lap 1: credited at e0+505, 50 ticks.
    push("lap_1", 2, 0, 1, 1);
    at(e0 + 503); set_pos(370, 50);
    at(e0 + 600); set_pos(100, 300);
    check("best_after_lap1", 32'(best_lap), 32'(BEST_LAP1));

    // Lap 2: credited at e0+800 on a tick cycle, 30 ticks including that tick.
    at(e0 + 650); set_pos(370, 650);
    at(e0 + 700); set_pos(100, 300);
    push("lap_2", 2, 0, 2, 1);
    at(e0 + 798); set_pos(370, 50);
    at(e0 + 850); set_pos(100, 300);

    // Lap 3: credited at e0+1205, 40 ticks; DONE next cycle, car_en off after.
    at(e0 + 900);  set_pos(370, 650);
    at(e0 + 1000); set_pos(100, 300);
    push("lap_3",      2, 0, 3, 1);
    push("done_enter", 3, 0, 3, 1);
    push("car_en_off", 3, 0, 3, 0);
    at(e0 + 1203); set_pos(370, 50);
    at(e0 + 1250); set_pos(100, 300);
    check("race_time_done", 32'(race_time), 32'd120);
    check("best_lap_done",  32'(best_lap),  32'(BEST_FIN));
    at(e0 + 1500);
    check("race_time_frozen", 32'(race_time), 32'd120);

    // DONE -> IDLE -> second race; best_lap survives the restart.
    push("idle_from_done", 0, 0, 3, 0);
    pulse_start;
    step(3);
    push("count2_enter", 1, 3, 0, 0);
    push("count2_2",     1, 2, 0, 0);
    push("count2_1",     1, 1, 0, 0);
    push("race2_enter",  2, 0, 0, 0);
    push("car_en2_on",   2, 0, 0, 1);
    race_seen = 1'b0;
    pulse_start;
    wait_race(e1);
    check("best_kept", 32'(best_lap), 32'(BEST_FIN));

    at(e1 + 100); set_pos(370, 650);
    at(e1 + 200); set_pos(100, 300);
    push("race2_lap_1", 2, 0, 1, 1);
    at(e1 + 403); set_pos(370, 50);
    at(e1 + 450); set_pos(100, 300);
    at(e1 + 500); set_pos(370, 650);
    at(e1 + 600); set_pos(100, 300);
    push("race2_lap_2", 2, 0, 2, 1);
    at(e1 + 803); set_pos(370, 50);
    at(e1 + 850); set_pos(100, 300);
    at(e1 + 900);
    check("race2_time", 32'(race_time), 32'd90);
    check("race2_best", 32'(best_lap),  32'(BEST_FIN));

    // Mid-race reset with lap=2: reset values on the next cycle.
    mon_en = 1'b0;
    rst = 1'b1;
    step(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    step(5);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
